// File: rtl/sdram_req_bridge.sv
// rtl/sdram_req_bridge.sv - multi-channel 8-bit client to 16-bit toggle-handshake SDRAM bridge
// Per-channel access detect and single-entry slot, round-robin grant, held read bytes.
module sdram_req_bridge #(
  parameter int              NCH       = 2,
  parameter int              AW        = 16,
  parameter logic [AW-1:0]   MASK_BASE = 16'hC000,
  parameter logic [AW-1:0]   MASK_SIZE = 16'h4000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_cs,
  input  logic [NCH-1:0]    ch_oe,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*8-1:0]  ch_din,
  output logic [NCH*8-1:0]  ch_dout,
  output logic [NCH-1:0]    ch_pend,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic [AW-1:0]     sd_a,
  output logic [1:0]        sd_ds,
  output logic              sd_we,
  output logic [15:0]       sd_d,
  input  logic [15:0]       sd_q
);

  localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t         state, state_next;
  logic [AW-1:0]  addr_c    [NCH];
  logic [AW-1:0]  prev_addr [NCH];
  logic [AW-1:0]  slot_addr [NCH];
  logic [7:0]     slot_din  [NCH];
  logic [NCH-1:0] cs_q, rd, wr, trig;
  logic [NCH-1:0] prev_rd, prev_wr;
  logic [NCH-1:0] slot_we, slot_valid, inflight;
  logic [RW-1:0]  rr, rr_next, cur, gnt_ch;
  logic           gnt_found, issue, done, ack_eq;

  function automatic logic is_masked(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - MASK_BASE;
    return (MASK_SIZE != '0) && (a >= MASK_BASE) && (off < MASK_SIZE);
  endfunction

  assign ack_eq  = (sd_ack == sd_req);
  assign ch_pend = slot_valid | inflight;

  // Access start: strobe rise, or a read whose address moved while oe stays high.
  always_comb begin
    cs_q = '0;
    rd   = '0;
    wr   = '0;
    trig = '0;
    for (int c = 0; c < NCH; c++) begin
      addr_c[c] = ch_addr[c*AW +: AW];
      cs_q[c]   = ch_cs[c] & ~is_masked(addr_c[c]);
      rd[c]     = cs_q[c] & ch_oe[c];
      wr[c]     = cs_q[c] & ch_we[c];
      trig[c]   = (rd[c] & ~prev_rd[c]) | (wr[c] & ~prev_wr[c]) |
                  (rd[c] & (addr_c[c] != prev_addr[c]));
    end
  end

  // Scan downwards so the lowest offset from rr is the last (winning) assignment.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (slot_valid[(int'(rr) + i) % NCH]) begin
        gnt_found = 1'b1;
        gnt_ch    = RW'((int'(rr) + i) % NCH);
      end
    end
    rr_next = RW'((int'(gnt_ch) + 1) % NCH);
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (gnt_found && ack_eq) begin
          issue      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_eq) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_rd    <= '0;
      prev_wr    <= '0;
      slot_we    <= '0;
      slot_valid <= '0;
      inflight   <= '0;
      rr         <= '0;
      cur        <= '0;
      ch_dout    <= '0;
      sd_req     <= 1'b0;
      sd_a       <= '0;
      sd_ds      <= 2'b11;
      sd_we      <= 1'b0;
      sd_d       <= '0;
      for (int c = 0; c < NCH; c++) begin
        prev_addr[c] <= '0;
        slot_addr[c] <= '0;
        slot_din[c]  <= '0;
      end
    end else begin
      prev_rd <= rd;
      prev_wr <= wr;
      for (int c = 0; c < NCH; c++) begin
        prev_addr[c] <= addr_c[c];
        if (trig[c]) begin
          slot_addr[c] <= addr_c[c];
          slot_we[c]   <= wr[c];
          slot_din[c]  <= ch_din[c*8 +: 8];
        end
        // A trigger on the edge the slot is granted re-arms it: set wins over clear.
        slot_valid[c] <= trig[c] | (slot_valid[c] & ~(issue && gnt_ch == RW'(c)));
        inflight[c]   <= (issue && gnt_ch == RW'(c)) |
                         (inflight[c] & ~(done && cur == RW'(c)));
        if (done && !sd_we && cur == RW'(c))
          ch_dout[c*8 +: 8] <= sd_a[0] ? sd_q[15:8] : sd_q[7:0];
      end
      if (issue) begin
        cur    <= gnt_ch;
        rr     <= rr_next;
        sd_a   <= slot_addr[gnt_ch];
        sd_we  <= slot_we[gnt_ch];
        sd_d   <= {2{slot_din[gnt_ch]}};
        sd_ds  <= slot_we[gnt_ch] ? (slot_addr[gnt_ch][0] ? 2'b10 : 2'b01) : 2'b11;
        sd_req <= ~sd_req;
      end
    end
  end

endmodule
